// File: rtl/sram_responder.sv
// Synchronous model of a 16-bit async-SRAM style device: active-low control pins,
// byte lanes, fixed read latency, and a power-on sweep that zeroes the array.
module sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        LB,
  input  logic        UB,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR,
    RD_WAIT,
    RD_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       lat_addr_q, lat_addr_d;
  logic [1:0]        lat_be_q, lat_be_d;
  logic              dout_valid_q, dout_valid_d;
  logic              addr_err_q, addr_err_d;

  logic [1:0]        req_be;
  logic              lanes_on;
  logic              in_range;
  logic              wr_req;
  logic              rd_req;
  logic              rd_abort;
  logic              accept_wr;

  logic              mem_we;
  logic [1:0]        mem_be;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic              out_load;
  logic              out_hold;

  // Lane enables are kept active-high internally: bit 0 = lower byte, bit 1 = upper byte.
  assign req_be   = ~{UB, LB};
  assign lanes_on = |req_be;
  assign in_range = ((addr >> ADDR_W) == 16'd0);
  assign wr_req   = !CE && !WE && lanes_on;
  assign rd_req   = !CE && WE && !OE && lanes_on;
  assign rd_abort = CE || OE || !WE || (addr != lat_addr_q) || (req_be != lat_be_q);

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_be_d   = lat_be_q;
    addr_err_d = 1'b0;
    out_load   = 1'b0;
    out_hold   = 1'b0;
    accept_wr  = 1'b0;
    mem_we     = 1'b0;
    mem_be     = req_be;
    mem_waddr  = addr[ADDR_W-1:0];
    mem_wdata  = din;

    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_be     = 2'b11;
        mem_waddr  = init_ptr_q;
        mem_wdata  = 16'h0000;
        init_ptr_d = init_ptr_q + 1'b1;
        if (&init_ptr_q) begin
          state_d = IDLE;
        end
      end
      IDLE, WR: begin
        state_d = IDLE;
        if (wr_req) begin
          accept_wr = 1'b1;
        end else if (rd_req) begin
          if (in_range) begin
            lat_addr_d = addr;
            lat_be_d   = req_be;
            cnt_d      = 2'(READ_LAT - 1);
            state_d    = RD_WAIT;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      RD_WAIT, RD_HOLD: begin
        if (rd_abort) begin
          // A write that breaks a read is still honoured at the same edge.
          state_d   = IDLE;
          accept_wr = wr_req;
        end else if (state_q == RD_HOLD) begin
          out_hold = 1'b1;
        end else if (cnt_q == 2'd0) begin
          out_load = 1'b1;
          state_d  = RD_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    if (accept_wr) begin
      if (in_range) begin
        mem_we  = 1'b1;
        state_d = WR;
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  assign dout_valid_d = out_load || out_hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= INIT;
      init_ptr_q   <= '0;
      cnt_q        <= '0;
      lat_addr_q   <= '0;
      lat_be_q     <= '0;
      dout_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      cnt_q        <= cnt_d;
      lat_addr_q   <= lat_addr_d;
      lat_be_q     <= lat_be_d;
      dout_valid_q <= dout_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // One byte-wide array per lane so each lane gets its own write enable.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] out_q;

    always_ff @(posedge clk) begin
      if (rst && mem_we && mem_be[gi]) begin
        mem_q[mem_waddr] <= mem_wdata[gi*8 +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst || !(out_load || out_hold)) begin
        out_q <= 8'h00;
      end else if (out_load) begin
        out_q <= lat_be_q[gi] ? mem_q[lat_addr_q[ADDR_W-1:0]] : 8'h00;
      end
    end
  end

  assign dout       = {g_lane[1].out_q, g_lane[0].out_q};
  assign dout_valid = dout_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = (state_q == INIT);

endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder: stimulus tasks push expected read data
// and error pulses into queues; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_sram_responder;

  localparam int ADDR_W   = 10;
  localparam int READ_LAT = 2;
  localparam int DEPTH    = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        CE = 1'b1, OE = 1'b1, WE = 1'b1, LB = 1'b1, UB = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        addr_err;

  sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .CE(CE), .OE(OE), .WE(WE), .LB(LB), .UB(UB),
    .addr(addr), .din(din), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [15:0] data; int cyc; } rd_exp_t;
  rd_exp_t     rdq[$];
  int          errq[$];
  logic [15:0] ref_mem [DEPTH];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_reset();
    foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
  endfunction

  function automatic void model_write(input int k, input logic [15:0] a, input logic [15:0] d,
                                      input logic lb, input logic ub);
    if (lb && ub) return;
    if (int'(a) >= DEPTH) begin
      errq.push_back(k);
      return;
    end
    if (!lb) ref_mem[a[ADDR_W-1:0]][7:0]  = d[7:0];
    if (!ub) ref_mem[a[ADDR_W-1:0]][15:8] = d[15:8];
  endfunction

  function automatic bit model_read(input int k, input logic [15:0] a, input logic lb, input logic ub);
    logic [15:0] m;
    if (lb && ub) return 1'b0;
    if (int'(a) >= DEPTH) begin
      errq.push_back(k);
      return 1'b0;
    end
    m = ref_mem[a[ADDR_W-1:0]];
    if (lb) m[7:0]  = 8'h00;
    if (ub) m[15:8] = 8'h00;
    rdq.push_back('{data: m, cyc: k + READ_LAT});
    return 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic ce, input logic oe, input logic we, input logic lb, input logic ub,
                       input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    CE = ce; OE = oe; WE = we; LB = lb; UB = ub; addr = a; din = d;
  endtask

  task automatic do_idle(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic lb, input logic ub);
    drive(1'b0, 1'b1, 1'b0, lb, ub, a, d);
    model_write(cyc + 1, a, d, lb, ub);
    $display("TXN write addr=%h data=%h LB=%0b UB=%0b", a, d, lb, ub);
  endtask

  task automatic do_read(input logic [15:0] a, input logic lb, input logic ub, input int hold);
    logic [15:0] d;
    bit started;
    d = 16'($urandom);
    drive(1'b0, 1'b0, 1'b1, lb, ub, a, d);
    started = model_read(cyc + 1, a, lb, ub);
    if (started) repeat (READ_LAT + hold) drive(1'b0, 1'b0, 1'b1, lb, ub, a, d);
    do_idle(1);
    $display("TXN read addr=%h LB=%0b UB=%0b hold=%0d started=%0b", a, lb, ub, hold, started);
  endtask

  // Valid in-range read broken off before its data is due.
  task automatic do_read_abort(input logic [15:0] a, input logic lb, input logic ub, input int kind);
    logic [1:0]  ln2;
    logic [15:0] wa, wd;
    int j;
    j = $urandom_range(1, READ_LAT - 1);
    drive(1'b0, 1'b0, 1'b1, lb, ub, a, 16'h0000);
    repeat (j - 1) drive(1'b0, 1'b0, 1'b1, lb, ub, a, 16'h0000);
    case (kind)
      0: drive(1'b0, 1'b1, 1'b1, lb, ub, a, 16'h0000);
      1: drive(1'b0, 1'b0, 1'b1, lb, ub, a ^ 16'h0001, 16'h0000);
      2: begin
        ln2 = {ub, lb} ^ 2'($urandom_range(1, 3));
        drive(1'b0, 1'b0, 1'b1, ln2[0], ln2[1], a, 16'h0000);
      end
      3: begin
        ln2 = 2'($urandom_range(0, 3));
        wa  = rand_addr();
        wd  = 16'($urandom);
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, ln2[0], ln2[1], wa, wd);
        model_write(cyc + 1, wa, wd, ln2[0], ln2[1]);
      end
      default: drive(1'b1, 1'b0, 1'b1, lb, ub, a, 16'h0000);
    endcase
    do_idle(1);
    $display("TXN read_abort addr=%h LB=%0b UB=%0b kind=%0d after=%0d", a, lb, ub, kind, j);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 16'($urandom_range(DEPTH, 65535));
    return 16'($urandom_range(0, 15));
  endfunction

  // Counts busy cycles sampled at negedges; returns at a negedge with busy low.
  task automatic wait_init(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_v;
    logic [15:0] held;
    rd_exp_t     e;
    int          ek;
    prev_v = 1'b0;
    held   = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (dout_valid === 1'b1 && !prev_v) begin
        if (rdq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got dout=%h at edge %0d, required no read data", dout, cyc);
        end else begin
          e = rdq.pop_front();
          check16("read_data", dout, e.data);
          check_int("read_latency_edge", cyc, e.cyc);
        end
        held = dout;
      end else if (dout_valid === 1'b1) begin
        check16("read_hold", dout, held);
      end else begin
        check16("dout_when_invalid", dout, 16'h0000);
        checks++;
        if (dout_valid !== 1'b0) begin
          failures++;
          $display("FAIL dout_valid_level: got %b required 0", dout_valid);
        end
      end
      while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
        e = rdq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_valid: got none at edge %0d, required data %h", e.cyc, e.data);
      end
      if (addr_err === 1'b1) begin
        if (errq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_addr_err: got 1 at edge %0d, required 0", cyc);
        end else begin
          ek = errq.pop_front();
          check_int("addr_err_edge", cyc, ek);
        end
      end else if (addr_err !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL addr_err_level: got %b required 0", addr_err);
      end
      while (errq.size() > 0 && errq[0] < cyc) begin
        ek = errq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_addr_err: got 0 at edge %0d, required 1", ek);
      end
      prev_v = (dout_valid === 1'b1);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : stim
    int n;
    int r;
    logic [1:0] ln;
    ref_reset();

    // Reset with a write request pending; it must not land, nor during INIT.
    CE = 1'b0; WE = 1'b0; OE = 1'b1; LB = 1'b0; UB = 1'b0; addr = 16'd5; din = 16'hFFFF;
    repeat (3) @(negedge clk);
    check16("reset_busy", 16'(busy), 16'h0001);
    check16("reset_dout", dout, 16'h0000);
    check16("reset_valid", 16'(dout_valid), 16'h0000);
    check16("reset_addr_err", 16'(addr_err), 16'h0000);
    rst = 1'b1;
    wait_init(n);
    CE = 1'b1; WE = 1'b1; LB = 1'b1; UB = 1'b1;
    check_int("busy_cycles", n, DEPTH);
    do_read(16'd5, 1'b0, 1'b0, 0);

    // Directed scenarios.
    do_read(16'(5678 % DEPTH), 1'b0, 1'b0, 0);
    do_write(16'd10, 16'd10, 1'b0, 1'b0);
    do_read(16'd10, 1'b0, 1'b0, 4);
    do_write(16'd3, 16'h1234, 1'b0, 1'b0);
    do_write(16'd3, 16'hABCD, 1'b1, 1'b0);
    do_read(16'd3, 1'b0, 1'b0, 1);
    do_read(16'd3, 1'b0, 1'b1, 1);
    do_write(16'h0400, 16'hFFFF, 1'b0, 1'b0);
    do_idle(1);
    do_read(16'd0, 1'b0, 1'b0, 0);
    do_read_abort(16'd10, 1'b0, 1'b0, 0);
    do_read(16'd10, 1'b0, 1'b0, 0);
    do_read_abort(16'd10, 1'b0, 1'b0, 3);
    do_write(16'd1, 16'h1111, 1'b1, 1'b1);

    // Randomized traffic over a small address window plus out-of-range hits.
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      ln = 2'($urandom_range(0, 3));
      if (r <= 3) begin
        do_write(rand_addr(), 16'($urandom), ln[0], ln[1]);
      end else if (r <= 6) begin
        do_read(rand_addr(), ln[0], ln[1], $urandom_range(0, 3));
      end else if (r <= 8) begin
        if (ln == 2'b11) ln = 2'b00;
        do_read_abort(16'($urandom_range(0, 15)), ln[0], ln[1], $urandom_range(0, 4));
      end else begin
        do_idle($urandom_range(0, 2));
      end
    end

    // Reset in the middle of RD_HOLD.
    do_write(16'd7, 16'h5678, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7, 16'h0000);
    void'(model_read(cyc + 1, 16'd7, 1'b0, 1'b0));
    repeat (READ_LAT + 2) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7, 16'h0000);
    check16("pre_reset_valid", 16'(dout_valid), 16'h0001);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check16("midread_reset_dout", dout, 16'h0000);
    check16("midread_reset_valid", 16'(dout_valid), 16'h0000);
    check16("midread_reset_busy", 16'(busy), 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    CE = 1'b1; OE = 1'b1; WE = 1'b1; LB = 1'b1; UB = 1'b1;
    ref_reset();
    wait_init(n);
    check_int("busy_cycles_rerst", n, DEPTH);
    do_read(16'd7, 1'b0, 1'b0, 1);

    do_idle(READ_LAT + 3);
    check_int("rd_queue_empty", rdq.size(), 0);
    check_int("err_queue_empty", errq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
